// File: rtl/conv_loader_pkg.sv
// Shared types and default widths for the conv_layer BRAM loader.
package conv_loader_pkg;

    localparam int unsigned DEF_DWIDTH       = 16;
    localparam int unsigned DEF_MAT_MUL_SIZE = 4;
    localparam int unsigned DEF_AWIDTH       = 10;
    localparam int unsigned DEF_SEL_WIDTH    = 8;

    localparam int unsigned WORD_W = DEF_MAT_MUL_SIZE * DEF_DWIDTH;
    localparam int unsigned LEN_W  = DEF_AWIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        FIN
    } state_t;

endpackage

// File: rtl/conv_loader_addr_gen.sv
// Beat counter and modulo-2**AWIDTH write address for one load burst.
module conv_loader_addr_gen #(
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [AWIDTH-1:0] load_base,
    input  logic [AWIDTH:0]   load_len,
    input  logic              beat,
    output logic [AWIDTH-1:0] addr_c,
    output logic              last_c
);

    localparam int unsigned W_LEN = AWIDTH + 1;

    logic [AWIDTH-1:0] base_q;
    logic [W_LEN-1:0]  len_q;
    logic [W_LEN-1:0]  count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            base_q  <= load_base;
            len_q   <= load_len;
            count_q <= '0;
        end else if (beat) begin
            count_q <= count_q + W_LEN'(1);
        end
    end

    // Address wraps naturally through the AWIDTH-bit adder.
    assign addr_c = base_q + count_q[AWIDTH-1:0];
    assign last_c = (count_q + W_LEN'(1)) == len_q;

endmodule

// File: rtl/conv_bram_loader.sv
// Streams words into a conv_layer BRAM external port, then optionally starts conv_layer.
module conv_bram_loader
    import conv_loader_pkg::*;
#(
    parameter int unsigned DWIDTH       = DEF_DWIDTH,
    parameter int unsigned MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
    parameter int unsigned AWIDTH       = DEF_AWIDTH,
    parameter int unsigned SEL_WIDTH    = DEF_SEL_WIDTH
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [SEL_WIDTH-1:0]           cfg_bram_sel,
    input  logic [AWIDTH-1:0]              cfg_base_addr,
    input  logic [AWIDTH:0]                cfg_len,
    input  logic [MAT_MUL_SIZE-1:0]        cfg_lane_mask,
    input  logic                           cfg_run,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] s_data,
    output logic [SEL_WIDTH-1:0]           bram_select,
    output logic [AWIDTH-1:0]              bram_addr_ext,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_ext,
    output logic [MAT_MUL_SIZE-1:0]        bram_we_ext,
    output logic                           conv_start,
    input  logic                           conv_done,
    output logic                           busy,
    output logic                           done
);

    state_t                  state, state_next;
    logic                    run_q;
    logic [MAT_MUL_SIZE-1:0] mask_q;

    logic                    accept_c, beat_c, last_c;
    logic [AWIDTH-1:0]       addr_c;

    logic                    cfg_ready_d, s_ready_d, busy_d, conv_start_d, done_d;
    logic [MAT_MUL_SIZE-1:0] we_d;

    conv_loader_addr_gen #(
        .AWIDTH (AWIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (resetn),
        .load      (accept_c),
        .load_base (cfg_base_addr),
        .load_len  (cfg_len),
        .beat      (beat_c),
        .addr_c    (addr_c),
        .last_c    (last_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_next   = state;
        cfg_ready_d  = 1'b0;
        conv_start_d = 1'b0;
        done_d       = 1'b0;
        we_d         = '0;
        accept_c     = cfg_valid && cfg_ready;
        beat_c       = s_valid && s_ready;

        case (state)
            IDLE: begin
                cfg_ready_d = !accept_c;
                if (accept_c) begin
                    if (cfg_len != '0) begin
                        state_next = LOAD;
                    end else if (cfg_run) begin
                        state_next = START;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            LOAD: begin
                if (beat_c) begin
                    we_d = mask_q;
                    if (last_c) begin
                        state_next = run_q ? START : FIN;
                    end
                end
            end
            START: begin
                conv_start_d = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                // A done level seen while our start pulse is still out is stale.
                if (conv_done && !conv_start) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done_d     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        s_ready_d = (state_next == LOAD);
        busy_d    = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cfg_ready      <= 1'b0;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            conv_start     <= 1'b0;
            done           <= 1'b0;
            bram_we_ext    <= '0;
            bram_addr_ext  <= '0;
            bram_wdata_ext <= '0;
            bram_select    <= '0;
            mask_q         <= '0;
            run_q          <= 1'b0;
        end else begin
            state       <= state_next;
            cfg_ready   <= cfg_ready_d;
            s_ready     <= s_ready_d;
            busy        <= busy_d;
            conv_start  <= conv_start_d;
            done        <= done_d;
            bram_we_ext <= we_d;
            if (beat_c) begin
                bram_addr_ext  <= addr_c;
                bram_wdata_ext <= s_data;
            end
            if (accept_c) begin
                bram_select <= cfg_bram_sel;
                mask_q      <= cfg_lane_mask;
                run_q       <= cfg_run;
            end
        end
    end

endmodule

// File: tb/tb_conv_bram_loader.sv
// Self-checking bench for conv_bram_loader against a cycle-stamped write-list model.
module tb_conv_bram_loader;
    import conv_loader_pkg::*;

    localparam int unsigned AW = 10;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [7:0]        cfg_bram_sel = '0;
    logic [AW-1:0]     cfg_base_addr = '0;
    logic [AW:0]       cfg_len = '0;
    logic [3:0]        cfg_lane_mask = '0;
    logic              cfg_run = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [WORD_W-1:0] s_data = '0;
    logic [7:0]        bram_select;
    logic [AW-1:0]     bram_addr_ext;
    logic [WORD_W-1:0] bram_wdata_ext;
    logic [3:0]        bram_we_ext;
    logic              conv_start;
    logic              conv_done = 1'b0;
    logic              busy;
    logic              done;

    conv_bram_loader dut (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bram_sel(cfg_bram_sel),
        .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_lane_mask(cfg_lane_mask),
        .cfg_run(cfg_run), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .bram_select(bram_select), .bram_addr_ext(bram_addr_ext),
        .bram_wdata_ext(bram_wdata_ext), .bram_we_ext(bram_we_ext),
        .conv_start(conv_start), .conv_done(conv_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [AW-1:0]     addr;
        logic [WORD_W-1:0] data;
        logic [3:0]        we;
    } wr_t;

    wr_t               obs_q[$];
    wr_t               exp_q[$];
    int                start_q[$];
    logic [WORD_W-1:0] beat_data[$];
    bit                s_ready_seen;
    int                ready_bad;
    int                n_tests = 0;
    int                n_fail = 0;
    int                cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed BRAM writes and start pulses, stamped with the cycle they are visible in.
    always @(negedge clk) begin
        if (bram_we_ext != 4'h0)
            obs_q.push_back('{32'(cyc), bram_addr_ext, bram_wdata_ext, bram_we_ext});
        if (conv_start === 1'b1) start_q.push_back(cyc);
        if (s_ready === 1'b1) s_ready_seen = 1'b1;
    end

    function automatic logic [WORD_W-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic clear_all();
        obs_q.delete(); exp_q.delete(); start_q.delete(); beat_data.delete();
        s_ready_seen = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] sel, input int base, input int len,
                          input logic [3:0] mask, input bit run, output int acc);
        int g;
        g = 0;
        @(negedge clk);
        while (cfg_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL cfg_ready_timeout: got %b expected 1", cfg_ready);
        end
        cfg_bram_sel = sel; cfg_base_addr = AW'(base); cfg_len = (AW+1)'(len);
        cfg_lane_mask = mask; cfg_run = run; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        acc = cyc;
    endtask

    // mode 0: every cycle, 1: alternate 1/0, 2: random gaps. Model: beat in cycle c writes in c+1.
    task automatic load_beats(input int base, input logic [3:0] mask, input int mode);
        int k, guard;
        bit v;
        k = 0; guard = 0; ready_bad = 0;
        while (k < beat_data.size() && guard < 4 * beat_data.size() + 50) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = beat_data[k];
            if (v) begin
                if (s_ready !== 1'b1) ready_bad++;
                exp_q.push_back('{32'(cyc + 1), AW'((base + k) % 1024), beat_data[k], mask});
                k++;
            end
            guard++;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({cfg_ready, s_ready, busy, done, conv_start, bram_we_ext, bram_select} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b srdy=%b busy=%b done=%b start=%b we=%b sel=%h expected all 0",
                     cfg_ready, s_ready, busy, done, conv_start, bram_we_ext, bram_select);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b busy=%b expected rdy=1 busy=0", cfg_ready, busy);
        end
    endtask

    task automatic test_basic_load();
        int acc, dc;
        clear_all();
        beat_data = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        do_cfg(8'd2, 0, 4, 4'hF, 1'b0, acc);
        load_beats(0, 4'hF, 0);
        wait_done(20, dc);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_wr[%0d]: got cyc=%0d addr=%0d data=%h we=%b expected cyc=%0d addr=%0d data=%h we=%b",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].we,
                         exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].we);
            end
        end
        n_tests++;
        if (dc != acc + 5) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d expected %0d", dc, acc + 5);
        end
        n_tests++;
        if (bram_select !== 8'd2 || start_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_sel_nostart: got sel=%0d starts=%0d expected sel=2 starts=0",
                     bram_select, start_q.size());
        end
        @(negedge clk);
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_after_done: got %b expected 1", cfg_ready);
        end
    endtask

    task automatic test_wrap_backpressure();
        int acc, dc;
        clear_all();
        for (int i = 0; i < 4; i++) beat_data.push_back(rand_word());
        do_cfg(8'd1, 1022, 4, 4'hF, 1'b0, acc);
        load_beats(1022, 4'hF, 1);
        wait_done(20, dc);
        n_tests++;
        if (obs_q.size() != 4 || ready_bad != 0) begin
            n_fail++;
            $display("FAIL wrap_wr_count: got %0d writes, %0d unready beats expected 4 writes, 0 unready",
                     obs_q.size(), ready_bad);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_wr[%0d]: got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data,
                         exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_tests++;
        if (dc != int'(exp_q[3].cyc) + 1) begin
            n_fail++;
            $display("FAIL wrap_done_cycle: got %0d expected %0d", dc, int'(exp_q[3].cyc) + 1);
        end
    endtask

    task automatic test_load_run();
        int acc, dc, s, base;
        clear_all();
        base = $urandom_range(0, 1023);
        for (int i = 0; i < 2; i++) beat_data.push_back(rand_word());
        conv_done = 1'b1;
        do_cfg(8'd3, base, 2, 4'hF, 1'b1, acc);
        load_beats(base, 4'hF, 0);
        s = -1;
        for (int i = 0; i < 10; i++) begin
            if (conv_start === 1'b1) begin
                s = cyc;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (s != int'(exp_q[1].cyc) + 1) begin
            n_fail++;
            $display("FAIL run_start_cycle: got %0d expected %0d", s, int'(exp_q[1].cyc) + 1);
        end
        @(negedge clk);
        conv_done = 1'b0;
        repeat (5) @(negedge clk);
        conv_done = 1'b1;
        // First honoured done is sampled at the end of cycle s+6.
        wait_done(20, dc);
        conv_done = 1'b0;
        n_tests++;
        if (dc != s + 8) begin
            n_fail++;
            $display("FAIL run_done_cycle: got %0d expected %0d", dc, s + 8);
        end
        n_tests++;
        if (start_q.size() != 1 || obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL run_pulse_count: got starts=%0d writes=%0d expected starts=1 writes=2",
                     start_q.size(), obs_q.size());
        end
    endtask

    task automatic test_zero_len();
        int acc, dc;
        clear_all();
        do_cfg(8'd4, 17, 0, 4'hF, 1'b0, acc);
        wait_done(20, dc);
        n_tests++;
        if (dc != acc + 1 || s_ready_seen || start_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_norun: got done=%0d srdy_seen=%0d starts=%0d writes=%0d expected done=%0d 0 0 0",
                     dc, s_ready_seen, start_q.size(), obs_q.size(), acc + 1);
        end
        clear_all();
        conv_done = 1'b1;
        do_cfg(8'd4, 17, 0, 4'hF, 1'b1, acc);
        wait_done(20, dc);
        conv_done = 1'b0;
        n_tests++;
        if (start_q.size() != 1 || (start_q.size() == 1 && start_q[0] != acc + 1)) begin
            n_fail++;
            $display("FAIL zero_run_start: got %0d pulses first=%0d expected 1 at %0d",
                     start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, acc + 1);
        end
        n_tests++;
        if (dc != acc + 4 || s_ready_seen) begin
            n_fail++;
            $display("FAIL zero_run_done: got done=%0d srdy_seen=%0d expected done=%0d srdy_seen=0",
                     dc, s_ready_seen, acc + 4);
        end
    endtask

    task automatic test_lane_mask_ignored();
        int acc, base, rdy_bad;
        logic [WORD_W-1:0] w;
        clear_all();
        base = $urandom_range(0, 1023);
        w = rand_word();
        rdy_bad = 0;
        do_cfg(8'd5, base, 1, 4'b0101, 1'b0, acc);
        s_valid = 1'b1; s_data = w;
        cfg_valid = 1'b1; cfg_bram_sel = 8'd7; cfg_len = 11'd3; cfg_lane_mask = 4'hF;
        exp_q.push_back('{32'(acc + 1), AW'(base), w, 4'b0101});
        if (cfg_ready !== 1'b0) rdy_bad++;
        @(negedge clk);
        s_valid = 1'b0;
        if (cfg_ready !== 1'b0) rdy_bad++;
        @(negedge clk);
        if (cfg_ready !== 1'b0) rdy_bad++;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_done: got %b expected 1", done);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rdy_bad != 0 || cfg_ready !== 1'b1 || busy !== 1'b0 || bram_select !== 8'd5) begin
            n_fail++;
            $display("FAIL mask_second_cfg: got rdy_bad=%0d rdy=%b busy=%b sel=%0d expected 0 1 0 5",
                     rdy_bad, cfg_ready, busy, bram_select);
        end
        n_tests++;
        if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
            n_fail++;
            $display("FAIL mask_write: got n=%0d we=%b addr=%0d expected n=1 we=0101 addr=%0d cyc=%0d",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].we : 4'h0,
                     (obs_q.size() > 0) ? obs_q[0].addr : '0, base, acc + 1);
        end
    endtask

    task automatic test_back_to_back();
        int acc, dc, base, len;
        logic [3:0] mask;
        logic [7:0] sel;
        for (int t = 0; t < 6; t++) begin
            clear_all();
            base = $urandom_range(0, 1023);
            len  = $urandom_range(1, 8);
            mask = 4'($urandom_range(1, 15));
            sel  = 8'($urandom_range(0, 255));
            for (int i = 0; i < len; i++) beat_data.push_back(rand_word());
            do_cfg(sel, base, len, mask, 1'b0, acc);
            load_beats(base, mask, 2);
            wait_done(20, dc);
            n_tests++;
            if (obs_q.size() != exp_q.size() || bram_select !== sel) begin
                n_fail++;
                $display("FAIL b2b[%0d]_count: got writes=%0d sel=%0d expected writes=%0d sel=%0d",
                         t, obs_q.size(), bram_select, exp_q.size(), sel);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]_wr[%0d]: got cyc=%0d addr=%0d we=%b expected cyc=%0d addr=%0d we=%b",
                             t, i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].we,
                             exp_q[i].cyc, exp_q[i].addr, exp_q[i].we);
                end
            end
            n_tests++;
            if (dc != int'(exp_q[exp_q.size() - 1].cyc) + 1) begin
                n_fail++;
                $display("FAIL b2b[%0d]_done: got %0d expected %0d", t, dc,
                         int'(exp_q[exp_q.size() - 1].cyc) + 1);
            end
        end
    endtask

    task automatic test_full_len();
        int acc, dc, base, bad, distinct;
        bit seen [1024];
        clear_all();
        base = $urandom_range(0, 1023);
        for (int i = 0; i < 1024; i++) beat_data.push_back(rand_word());
        do_cfg(8'd9, base, 1024, 4'hF, 1'b0, acc);
        load_beats(base, 4'hF, 0);
        wait_done(20, dc);
        bad = 0;
        distinct = 0;
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (!seen[obs_q[i].addr]) distinct++;
            seen[obs_q[i].addr] = 1'b1;
            if (i < exp_q.size() && obs_q[i] !== exp_q[i]) bad++;
        end
        n_tests++;
        if (obs_q.size() != 1024 || distinct != 1024 || bad != 0) begin
            n_fail++;
            $display("FAIL full_len_writes: got n=%0d distinct=%0d wrong=%0d expected 1024 1024 0",
                     obs_q.size(), distinct, bad);
        end
        n_tests++;
        if (dc != acc + 1025) begin
            n_fail++;
            $display("FAIL full_len_done: got %0d expected %0d", dc, acc + 1025);
        end
    endtask

    task automatic test_reset_mid_load();
        int acc, base;
        clear_all();
        base = $urandom_range(0, 1023);
        do_cfg(8'd6, base, 8, 4'hF, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = rand_word();
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_tests++;
        if (bram_we_ext !== 4'hF || bram_addr_ext !== AW'((base + 2) % 1024)) begin
            n_fail++;
            $display("FAIL rst_pre_write: got we=%b addr=%0d expected we=1111 addr=%0d",
                     bram_we_ext, bram_addr_ext, (base + 2) % 1024);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({bram_we_ext, conv_start, done, busy, cfg_ready, s_ready} !== '0) begin
            n_fail++;
            $display("FAIL rst_immediate: got we=%b start=%b done=%b busy=%b rdy=%b srdy=%b expected all 0",
                     bram_we_ext, conv_start, done, busy, cfg_ready, s_ready);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        obs_q.delete();
        start_q.delete();
        s_valid = 1'b1;
        s_data  = rand_word();
        @(negedge clk);
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_idle: got rdy=%b busy=%b srdy=%b expected 1 0 0",
                     cfg_ready, busy, s_ready);
        end
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        n_tests++;
        if (obs_q.size() != 0 || start_q.size() != 0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_no_resume: got writes=%0d starts=%0d rdy=%b expected 0 0 1",
                     obs_q.size(), start_q.size(), cfg_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_wrap_backpressure();
        test_load_run();
        test_zero_len();
        test_lane_mask_ignored();
        test_back_to_back();
        test_full_len();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_bram_loader.md
Name: conv_bram_loader

Overview:
- Upstream stage of conv_layer: streams matrix data into one conv_layer BRAM through its external port (bram_select/bram_addr_ext/bram_wdata_ext/bram_we_ext).
- Optionally fires conv_layer start after the load and waits for conv_layer done.
- Deterministic, handshaked replacement for random external-port stimulus; lets the bench load A/B matrices before a run.

Parameters:
- DWIDTH, 16, element width.
- MAT_MUL_SIZE, 4, elements per BRAM word; also the number of write-enable lanes.
- AWIDTH, 10, BRAM address width (MEM_SIZE = 2**AWIDTH).
- SEL_WIDTH, 8, bram_select width.

Ports:
- clk  in  1  single clock; every register is in this domain.
- resetn  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  loader idle and able to accept a config.
- cfg_bram_sel  in  SEL_WIDTH  target BRAM id.
- cfg_base_addr  in  AWIDTH  first word address.
- cfg_len  in  AWIDTH+1  words to write, 0..2**AWIDTH.
- cfg_lane_mask  in  MAT_MUL_SIZE  per-element write lanes.
- cfg_run  in  1  pulse conv_start after the load.
- s_valid  in  1  data beat valid.
- s_ready  out  1  loader accepts a beat.
- s_data  in  MAT_MUL_SIZE*DWIDTH  one BRAM word.
- bram_select  out  SEL_WIDTH  to conv_layer.
- bram_addr_ext  out  AWIDTH  to conv_layer.
- bram_wdata_ext  out  MAT_MUL_SIZE*DWIDTH  to conv_layer.
- bram_we_ext  out  MAT_MUL_SIZE  to conv_layer.
- conv_start  out  1  conv_layer start pulse.
- conv_done  in  1  conv_layer done (level).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, resetn=0): state IDLE and all outputs 0, including cfg_ready.
  - cfg_ready rises on the first clk edge after resetn deasserts.
  - Reset mid-operation aborts immediately; bram_we_ext drops without waiting for a clock; the partial load is not resumed.
- All outputs are registered.
- States: IDLE, LOAD, START, WAIT, FIN.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, latch all cfg fields; cfg_ready=0 from the next cycle.
  - bram_select takes cfg_bram_sel the next cycle and holds it until the next accepted config.
  - Next state: LOAD if cfg_len!=0; else START if cfg_run; else FIN.
- LOAD:
  - s_ready=1 while count<len.
  - On a beat (s_valid&&s_ready), the next cycle drives bram_addr_ext=(base+count) mod 2**AWIDTH, bram_wdata_ext=s_data and bram_we_ext=cfg_lane_mask. This is 1-cycle latency.
  - Then count increments.
  - bram_we_ext=0 on cycles with no beat; addr and wdata hold their last value.
  - Address wraps silently from 1023 to 0.
  - s_valid gaps stall the load without limit.
  - After the last beat is accepted, s_ready=0 the next cycle; that cycle carries the final write.
  - Next state after the final write cycle: START if cfg_run, else FIN.
- START: conv_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - conv_done is ignored in the cycle conv_start is high.
  - From the following cycle, conv_done=1 moves the FSM to FIN.
  - No timeout.
- FIN: done=1 for one cycle, then IDLE. cfg_ready=1 in the cycle after done.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- s_valid outside LOAD is ignored (s_ready=0).
- cfg_len=2**AWIDTH writes every address exactly once, wrapping back to base.
- busy = (state!=IDLE), registered with state.

Decomposition:
- conv_loader_pkg holds:
  - state enum {IDLE, LOAD, START, WAIT, FIN};
  - localparams WORD_W=MAT_MUL_SIZE*DWIDTH and LEN_W=AWIDTH+1;
  - the default widths.
- One sub-module, conv_loader_addr_gen:
  - beat counter plus modulo address adder;
  - inputs: load base/len, beat strobe;
  - outputs: addr, last.
- The FSM and output registers live in the top.

Test Plan:
- Basic load, no run:
  - Stimulus: cfg sel=2, base=0, len=4, mask=4'hF, run=0; beats 0x1111..,0x2222..,0x3333..,0x4444.. back-to-back.
  - Response: we=F at addr 0,1,2,3 on consecutive cycles, each 1 cycle after its beat; bram_select=2; conv_start never high; done pulse 1 cycle after the last write; cfg_ready=1 the next cycle.
- Wrap and backpressure:
  - Stimulus: base=1022, len=4; s_valid toggling 1,0,1,0.
  - Response: addresses 1022,1023,0,1; we=0 on gap cycles; exactly 4 writes.
- Load plus run:
  - Stimulus: len=2, run=1; conv_done held 1 before and during conv_start, then 0 for 5 cycles, then 1.
  - Response: one conv_start pulse after the final write; the stale done in the conv_start cycle is ignored; done pulse 1 cycle after conv_done=1 is sampled in WAIT.
- Zero length:
  - Stimulus: len=0, run=0.
  - Response: s_ready never 1; done 2 cycles after cfg accept. With run=1: conv_start 2 cycles after accept.
- Lane mask and ignored config:
  - Stimulus: mask=4'b0101, len=1; a second cfg_valid during LOAD.
  - Response: bram_we_ext=0101; the second cfg is not accepted.
- Reset mid-load:
  - Stimulus: len=8; assert resetn=0 after 3 beats, between clock edges.
  - Response: we, conv_start, done, busy and cfg_ready go 0 immediately; after release the loader is IDLE with cfg_ready=1 and no further writes.
